// File: rtl/sysarr_pkg.sv
// Shared definitions for the 4x4 systolic array feeder: array size, stream length, FSM states.
// Latency: n/a (types, constants and a slicing helper only).
// Backpressure: n/a.
package sysarr_pkg;

  localparam int N          = 4;
  localparam int STREAM_LEN = 2 * N - 1;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  // LSB position of element idx inside a packed vector of dw-wide elements.
  // Rows, columns and the result matrix all use this packing.
  function automatic int elem_lsb(input int idx, input int dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Diagonal-skew selector for one array input lane: picks vec[t - LANE] or 0 outside the window.
// Latency: combinational; the caller registers the result.
// Backpressure: none, pure function of its inputs.
// Ports: vec_i   - 4-element packed row (A lanes) or column (B lanes)
//        t_i     - STREAM cycle index the output is meant for
//        elem_o  - skewed element, 0 when t_i - LANE is outside 0..N-1
module skew_lane_mux
  import sysarr_pkg::*;
#(
  parameter int DW   = 32,
  parameter int LANE = 0
) (
  input  logic [N*DW-1:0] vec_i,
  input  logic [3:0]      t_i,
  output logic [DW-1:0]   elem_o
);

  logic [DW-1:0] el [N];
  logic [4:0]    diff;

  for (genvar g = 0; g < N; g++) begin : g_split
    assign el[g] = vec_i[elem_lsb(g, DW) +: DW];
  end

  // Unsigned subtraction: a "negative" offset wraps to a large value, so a
  // single compare against N rejects both ends of the window.
  assign diff = {1'b0, t_i} - 5'(LANE);

  always_comb begin
    elem_o = '0;
    if (diff < 5'(N)) begin
      elem_o = el[diff[1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder_4x4.sv
// Loads A (rows) and B (columns), clears the array, streams skewed lanes, drains, captures C.
// Latency: last load beat to result_valid = 1 + STREAM_LEN + DRAIN_CYCLES cycles.
// Backpressure: load_ready low outside LOAD; result held in HOLD until result_ready.
// Ports: clk/rst (sync active-low); load_valid/load_ready/load_a_row/load_b_col load side;
//        array_rst, lane_a0..3, lane_b0..3, array_res array side;
//        result/result_valid/result_ready consumer side; busy = not in LOAD.
module systolic_feeder_4x4
  import sysarr_pkg::*;
#(
  parameter int DW           = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*DW-1:0]   load_a_row,
  input  logic [4*DW-1:0]   load_b_col,
  output logic              array_rst,
  output logic [DW-1:0]     lane_a0,
  output logic [DW-1:0]     lane_a1,
  output logic [DW-1:0]     lane_a2,
  output logic [DW-1:0]     lane_a3,
  output logic [DW-1:0]     lane_b0,
  output logic [DW-1:0]     lane_b1,
  output logic [DW-1:0]     lane_b2,
  output logic [DW-1:0]     lane_b3,
  input  logic [16*DW-1:0]  array_res,
  output logic [16*DW-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy
);

  state_e            state_q;
  logic [1:0]        beat_q;
  logic [3:0]        cnt_q;          // STREAM cycle index, then DRAIN cycle index
  logic              load_ready_q;
  logic              array_rst_q;
  logic              result_valid_q;
  logic [16*DW-1:0]  result_q;
  logic [N*DW-1:0]   a_row_q [N];
  logic [N*DW-1:0]   b_col_q [N];
  logic [DW-1:0]     lane_a_q [N];
  logic [DW-1:0]     lane_b_q [N];
  logic [DW-1:0]     mux_a [N];
  logic [DW-1:0]     mux_b [N];

  logic              load_fire;
  logic              stream_d;       // the coming cycle is a STREAM cycle
  logic [3:0]        t_d;            // STREAM index of the coming cycle

  assign load_fire = rst && load_valid && load_ready_q && (state_q == ST_LOAD);

  // Lanes are registered, so the selectors look one cycle ahead: the edge
  // leaving CLEAR must already load the t=0 values.
  always_comb begin
    stream_d = 1'b0;
    t_d      = '0;
    if (state_q == ST_CLEAR) begin
      stream_d = 1'b1;
    end else if (state_q == ST_STREAM && cnt_q != 4'(STREAM_LEN - 1)) begin
      stream_d = 1'b1;
      t_d      = cnt_q + 4'd1;
    end
  end

  // A lane r walks row r; B lane c walks column c. Same skew rule for both.
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_mux #(.DW(DW), .LANE(g)) u_mux_a (
      .vec_i  (a_row_q[g]),
      .t_i    (t_d),
      .elem_o (mux_a[g])
    );
    skew_lane_mux #(.DW(DW), .LANE(g)) u_mux_b (
      .vec_i  (b_col_q[g]),
      .t_i    (t_d),
      .elem_o (mux_b[g])
    );
  end

  // Operand buffers carry no reset: they are fully rewritten before every use.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      a_row_q[beat_q] <= load_a_row;
      b_col_q[beat_q] <= load_b_col;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_LOAD;
      beat_q         <= '0;
      cnt_q          <= '0;
      load_ready_q   <= 1'b1;
      array_rst_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      for (int i = 0; i < N; i++) begin
        lane_a_q[i] <= '0;
        lane_b_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        lane_a_q[i] <= stream_d ? mux_a[i] : '0;
        lane_b_q[i] <= stream_d ? mux_b[i] : '0;
      end
      // Array reset is released everywhere except during the single CLEAR cycle.
      array_rst_q <= 1'b1;

      case (state_q)
        ST_LOAD: begin
          if (load_fire) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              state_q      <= ST_CLEAR;
              load_ready_q <= 1'b0;
              array_rst_q  <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          state_q <= ST_STREAM;
          cnt_q   <= '0;
        end
        ST_STREAM: begin
          if (cnt_q == 4'(STREAM_LEN - 1)) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == 4'(DRAIN_CYCLES - 1)) begin
            state_q        <= ST_HOLD;
            cnt_q          <= '0;
            result_q       <= array_res;
            result_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_HOLD: begin
          if (result_ready) begin
            state_q        <= ST_LOAD;
            result_valid_q <= 1'b0;
            load_ready_q   <= 1'b1;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign load_ready   = load_ready_q;
  assign array_rst    = array_rst_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != ST_LOAD);
  assign lane_a0      = lane_a_q[0];
  assign lane_a1      = lane_a_q[1];
  assign lane_a2      = lane_a_q[2];
  assign lane_a3      = lane_a_q[3];
  assign lane_b0      = lane_b_q[0];
  assign lane_b1      = lane_b_q[1];
  assign lane_b2      = lane_b_q[2];
  assign lane_b3      = lane_b_q[3];

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Scoreboard bench for systolic_feeder_4x4: drivers push expected lane snapshots and results,
// monitors pop and compare whenever a stream starts or result_valid rises.
// Clock 10 ns; inputs change 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_systolic_feeder_4x4;

  logic           clk;
  logic           rst;
  logic           load_valid;
  logic           load_ready;
  logic [127:0]   load_a_row;
  logic [127:0]   load_b_col;
  logic           array_rst;
  logic [31:0]    lane_a0, lane_a1, lane_a2, lane_a3;
  logic [31:0]    lane_b0, lane_b1, lane_b2, lane_b3;
  logic [511:0]   array_res;
  logic [511:0]   result;
  logic           result_valid;
  logic           result_ready;
  logic           busy;

  systolic_feeder_4x4 dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_a_row   (load_a_row),
    .load_b_col   (load_b_col),
    .array_rst    (array_rst),
    .lane_a0      (lane_a0),
    .lane_a1      (lane_a1),
    .lane_a2      (lane_a2),
    .lane_a3      (lane_a3),
    .lane_b0      (lane_b0),
    .lane_b1      (lane_b1),
    .lane_b2      (lane_b2),
    .lane_b3      (lane_b3),
    .array_res    (array_res),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_beat_cyc = 0;

  logic [31:0]  A_m [4][4];
  logic [31:0]  B_m [4][4];
  logic [255:0] lane_exp [$];
  logic [511:0] res_exp [$];
  int           stream_idx = -1;
  bit           prev_arst = 1'b0;
  bit           expect_abort = 1'b0;
  bit           rv_prev = 1'b0;
  logic [511:0] held_res = '0;

  // Hand-derived lanes for A[r][k] = 16r+k+1, B = identity: {a0,a1,a2,a3,b0,b1,b2,b3} per t.
  logic [31:0] tab1 [7][8] = '{
    '{32'd1, 32'd0,  32'd0,  32'd0,  32'd1, 32'd0, 32'd0, 32'd0},
    '{32'd2, 32'd17, 32'd0,  32'd0,  32'd0, 32'd0, 32'd0, 32'd0},
    '{32'd3, 32'd18, 32'd33, 32'd0,  32'd0, 32'd1, 32'd0, 32'd0},
    '{32'd4, 32'd19, 32'd34, 32'd49, 32'd0, 32'd0, 32'd0, 32'd0},
    '{32'd0, 32'd20, 32'd35, 32'd50, 32'd0, 32'd0, 32'd1, 32'd0},
    '{32'd0, 32'd0,  32'd36, 32'd51, 32'd0, 32'd0, 32'd0, 32'd0},
    '{32'd0, 32'd0,  32'd0,  32'd52, 32'd0, 32'd0, 32'd0, 32'd1}
  };

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst && load_valid && load_ready) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] cur_snap();
    return {lane_a0, lane_a1, lane_a2, lane_a3, lane_b0, lane_b1, lane_b2, lane_b3};
  endfunction

  function automatic logic [255:0] tab_snap(input int t);
    logic [255:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[(7-i)*32 +: 32] = tab1[t][i];
    return s;
  endfunction

  function automatic logic [255:0] model_snap(input int t);
    logic [255:0] s;
    s = '0;
    for (int r = 0; r < 4; r++)
      if (t - r >= 0 && t - r <= 3) s[(7-r)*32 +: 32] = A_m[r][t-r];
    for (int c = 0; c < 4; c++)
      if (t - c >= 0 && t - c <= 3) s[(3-c)*32 +: 32] = B_m[t-c][c];
    return s;
  endfunction

  function automatic logic [127:0] pack_row(input int k);
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = A_m[k][j];
    return v;
  endfunction

  function automatic logic [127:0] pack_col(input int k);
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = B_m[j][k];
    return v;
  endfunction

  task automatic set_mats(input int sel);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        if (sel == 1) begin
          A_m[r][k] = 32'(16 * r + k + 1);
          B_m[r][k] = (r == k) ? 32'd1 : 32'd0;
        end else if (sel == 2) begin
          A_m[r][k] = 32'(32'h1000 + 16 * r + k);
          B_m[r][k] = 32'(32'h2000 + 16 * r + k);
        end else begin
          A_m[r][k] = 32'(32'h3000 + 16 * r + k);
          B_m[r][k] = 32'(32'h4000 + 16 * r + k);
        end
      end
  endtask

  task automatic set_stub(input int base);
    for (int i = 0; i < 16; i++) array_res[i*32 +: 32] = 32'(base + i);
  endtask

  // Drive four beats; push nsnap expected lane snapshots and optionally the expected result.
  task automatic do_load(input bit toggle, input int nsnap, input bit use_tab, input bit push_res);
    int a0;
    int w;
    bit got;
    a0 = acc_cnt;
    for (int t = 0; t < nsnap; t++) lane_exp.push_back(use_tab ? tab_snap(t) : model_snap(t));
    if (push_res) res_exp.push_back(array_res);
    for (int k = 0; k < 4; k++) begin
      if (toggle && k > 0) begin
        load_valid = 1'b0;
        @(posedge clk); #1;
      end
      load_valid = 1'b1;
      load_a_row = pack_row(k);
      load_b_col = pack_col(k);
      w = 0;
      got = 1'b0;
      while (!got && w < 50) begin
        @(negedge clk);
        got = load_ready;
        @(posedge clk); #1;
        w++;
      end
      chk($sformatf("load_beat%0d_accepted", k), 512'(got), 512'(1));
    end
    last_beat_cyc = cyc;
    load_valid = 1'b0;
    chk("beats_accepted", 512'(acc_cnt - a0), 512'(4));
  endtask

  task automatic wait_result();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!result_valid && w < 100);
    chk("result_valid_seen", 512'(result_valid), 512'(1));
    @(posedge clk); #1;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    load_valid   = 1'b0;
    @(posedge clk); #1;
    result_ready = 1'b0;
    #3;
    chk("rv_low_after_handshake", 512'(result_valid), 512'(0));
    chk("load_ready_after_handshake", 512'(load_ready), 512'(1));
    chk("busy_low_after_handshake", 512'(busy), 512'(0));
  endtask

  // Lane monitor: CLEAR (busy with array_rst low) announces a 7-cycle stream.
  always @(negedge clk) begin
    logic [255:0] s;
    s = cur_snap();
    if (stream_idx >= 0 && !busy) begin
      if (expect_abort) expect_abort = 1'b0;
      else chk("stream_interrupted", 512'(busy), 512'(1));
      stream_idx = -1;
    end else if (stream_idx >= 0) begin
      if (lane_exp.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL lane_unexpected: got %0h, expected no stream", s);
      end else begin
        chk($sformatf("lane_t%0d", stream_idx), 512'(s), 512'(lane_exp.pop_front()));
      end
      if (stream_idx == 0) chk("arst_high_at_t0", 512'(array_rst), 512'(1));
      stream_idx++;
      if (stream_idx == 7) stream_idx = -2;
    end else if (stream_idx == -2) begin
      chk("lanes_zero_after_stream", 512'(s), 512'(0));
      stream_idx = -1;
    end else if (busy && !array_rst) begin
      chk("arst_high_before_clear", 512'(prev_arst), 512'(1));
      stream_idx = 0;
    end
    prev_arst = array_rst;
  end

  // Result monitor: value and latency on the rising edge of result_valid, stability while held.
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (res_exp.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL result_unexpected: got %0h, expected no result", result);
      end else begin
        chk("result_value", result, res_exp.pop_front());
      end
      chk("result_latency", 512'(cyc - last_beat_cyc), 512'(12));
      held_res = result;
    end else if (result_valid) begin
      chk("result_stable", result, held_res);
      chk("load_ready_low_in_hold", 512'(load_ready), 512'(0));
    end
    rv_prev = result_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b0;
    load_valid = 1'b0;
    load_a_row = '0;
    load_b_col = '0;
    array_res = '0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_load_ready", 512'(load_ready), 512'(1));
    chk("rst_result_valid", 512'(result_valid), 512'(0));
    chk("rst_result", result, 512'(0));
    chk("rst_lanes", 512'(cur_snap()), 512'(0));
    chk("rst_array_rst", 512'(array_rst), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Continuous-valid load, result held 10 cycles with result_ready low.
    set_mats(1);
    set_stub(32'h100);
    do_load(1'b0, 7, 1'b1, 1'b1);
    wait_result();
    repeat (10) begin @(posedge clk); #1; end
    handshake();

    // Back-to-back load with load_valid toggling; same stream expected.
    set_stub(32'h200);
    do_load(1'b1, 7, 1'b1, 1'b1);
    wait_result();
    handshake();

    // load_valid held high with junk through CLEAR/STREAM/DRAIN/HOLD must be ignored.
    set_mats(2);
    set_stub(32'h300);
    do_load(1'b0, 7, 1'b0, 1'b1);
    a0 = acc_cnt;
    load_valid = 1'b1;
    load_a_row = '1;
    load_b_col = '1;
    wait_result();
    repeat (3) begin @(posedge clk); #1; end
    handshake();
    chk("no_beats_outside_load", 512'(acc_cnt - a0), 512'(0));

    // Reset asserted during STREAM t=3; the load must be discarded.
    set_mats(3);
    set_stub(32'h400);
    expect_abort = 1'b1;
    do_load(1'b0, 4, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    #3;
    chk("midrst_lanes", 512'(cur_snap()), 512'(0));
    chk("midrst_array_rst", 512'(array_rst), 512'(0));
    chk("midrst_result_valid", 512'(result_valid), 512'(0));
    chk("midrst_load_ready", 512'(load_ready), 512'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("stream_abort_seen", 512'(expect_abort), 512'(0));

    // Fresh load after reset.
    set_mats(2);
    set_stub(32'h500);
    do_load(1'b0, 7, 1'b0, 1'b1);
    wait_result();
    handshake();

    repeat (3) begin @(posedge clk); #1; end
    chk("lane_queue_empty", 512'(lane_exp.size()), 512'(0));
    chk("result_queue_empty", 512'(res_exp.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
